// File: rtl/aclk_pkg.sv
// aclk_pkg: shared defaults, mode enum and digit-extract helper for the alarm-clock key buffer
//   DIGIT_W_DEF / KEY_MAX_DEF : default key-code width and largest accepted code
//   mode_t                    : buffer fill mode
//   digit_at()                : digit i of a flat digit bus (up to 8 digits of up to 8 bits)
package aclk_pkg;
    localparam int DIGIT_W_DEF = 4;
    localparam int KEY_MAX_DEF = 9;

    typedef enum logic [1:0] {MODE_EMPTY, MODE_ENTRY, MODE_FULL} mode_t;

    function automatic logic [7:0] digit_at(input logic [63:0] flat, input int i, input int w);
        digit_at = 8'((flat >> (i * w)) & ((64'd1 << w) - 64'd1));
    endfunction
endpackage

// File: rtl/aclk_keybuf_if.sv
// aclk_keybuf_if: keypad-side command strobes and registered digit-buffer outputs
//   master: drives key/shift/backspace/clear/tick, observes digits/count/full/key_err/timeout
//   slave : the key buffer itself
interface aclk_keybuf_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = aclk_pkg::DIGIT_W_DEF
);
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic [DIGIT_W-1:0]            key;
    logic                          shift;
    logic                          backspace;
    logic                          clear;
    logic                          tick;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    logic [CW-1:0]                 count;
    logic                          full;
    logic                          key_err;
    logic                          timeout;

    modport master (
        output key, shift, backspace, clear, tick,
        input  digits, count, full, key_err, timeout
    );

    modport slave (
        input  key, shift, backspace, clear, tick,
        output digits, count, full, key_err, timeout
    );
endinterface

// File: rtl/aclk_idle_timer.sv
// aclk_idle_timer: counts enabled ticks and pulses done on the TIMEOUT_TICKS-th one (0 disables)
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clr_i        : zero the count (activity); suppresses done in the same cycle
//   en_i         : qualified tick
//   done_o       : combinational, high in the cycle whose edge completes the count
module aclk_idle_timer #(
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);
    localparam int TW = TIMEOUT_TICKS > 0 ? $clog2(TIMEOUT_TICKS + 1) : 1;

    logic [TW-1:0] cnt_q;

    assign done_o = TIMEOUT_TICKS > 0 && en_i && !clr_i && cnt_q == TW'(TIMEOUT_TICKS - 1);

    always_ff @(posedge clock) begin
        if (reset || clr_i || done_o)
            cnt_q <= '0;
        else if (en_i && TIMEOUT_TICKS > 0)
            cnt_q <= cnt_q + TW'(1);
    end
endmodule

// File: rtl/aclk_keybuf.sv
// aclk_keybuf: shift buffer of key digits with count, backspace, clear, invalid-key reject and idle timeout
//   clock, reset : rising-edge clock, synchronous active-high reset
//   kb (slave)   : key/shift/backspace/clear/tick in; digits/count/full/key_err/timeout out (all registered)
module aclk_keybuf
    import aclk_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int DIGIT_W       = DIGIT_W_DEF,
    parameter int KEY_MAX       = KEY_MAX_DEF,
    parameter int TIMEOUT_TICKS = 10
) (
    input logic          clock,
    input logic          reset,
    aclk_keybuf_if.slave kb
);
    localparam int            CW   = $clog2(NUM_DIGITS + 1);
    localparam int            BW   = NUM_DIGITS * DIGIT_W;
    localparam logic [CW-1:0] CMAX = CW'(NUM_DIGITS);

    logic [BW-1:0] dig_q, dig_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d, to_q;
    mode_t         mode_q, mode_d;
    logic          valid, do_bs, do_sh, act, fire, wipe;

    // Priority clear > backspace > shift; a backspace on an empty buffer still blocks a shift.
    always_comb begin
        valid  = kb.key <= DIGIT_W'(KEY_MAX);
        do_bs  = !kb.clear && kb.backspace && cnt_q != '0;
        do_sh  = !kb.clear && !kb.backspace && kb.shift;
        act    = kb.clear || do_bs || do_sh;
        wipe   = kb.clear || fire;
        dig_d  = wipe ? '0 :
                 do_bs ? {DIGIT_W'(0), dig_q[BW-1:DIGIT_W]} :
                 do_sh && valid ? {dig_q[BW-DIGIT_W-1:0], kb.key} : dig_q;
        cnt_d  = wipe ? '0 :
                 do_bs ? cnt_q - CW'(1) :
                 do_sh && valid && cnt_q != CMAX ? cnt_q + CW'(1) : cnt_q;
        err_d  = do_sh && !valid;
        mode_d = cnt_d == '0 ? MODE_EMPTY : cnt_d == CMAX ? MODE_FULL : MODE_ENTRY;
    end

    always_ff @(posedge clock) begin
        if (reset)
            mode_q <= MODE_EMPTY;
        else
            mode_q <= mode_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dig_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            dig_q <= dig_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            to_q  <= fire;
        end
    end

    // Any command (including a rejected key) counts as activity and zeroes the idle count.
    aclk_idle_timer #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (act),
        .en_i   (kb.tick && mode_q == MODE_ENTRY),
        .done_o (fire)
    );

    assign kb.digits  = dig_q;
    assign kb.count   = cnt_q;
    assign kb.full    = mode_q == MODE_FULL;
    assign kb.key_err = err_q;
    assign kb.timeout = to_q;
endmodule

// File: tb/tb_aclk_keybuf.sv
// tb_aclk_keybuf: table-driven, directed and random checks of a 4-digit and a 6-digit key buffer
module tb_aclk_keybuf;
    import aclk_pkg::*;

    typedef struct {
        logic        r, c, b, s;
        logic [3:0]  k;
        logic        t;
        logic [15:0] d;
        int          n;
        logic        e, o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, clr, bs, sh, tick;
    logic [3:0] key;
    int         checks = 0;
    int         errors = 0;

    int MN[2] = '{4, 6};
    int MT[2] = '{3, 10};
    int md[2][8];
    int mc[2], mt[2];
    bit me[2], mo[2];

    vec_t tv[$];

    aclk_keybuf_if #(.NUM_DIGITS(4), .DIGIT_W(4)) ia();
    aclk_keybuf_if #(.NUM_DIGITS(6), .DIGIT_W(4)) ib();

    assign ia.key = key;  assign ia.shift = sh;  assign ia.backspace = bs;
    assign ia.clear = clr; assign ia.tick = tick;
    assign ib.key = key;  assign ib.shift = sh;  assign ib.backspace = bs;
    assign ib.clear = clr; assign ib.tick = tick;

    aclk_keybuf #(.NUM_DIGITS(4), .DIGIT_W(4), .KEY_MAX(9), .TIMEOUT_TICKS(3)) u_a (
        .clock(clk), .reset(rst), .kb(ia)
    );
    aclk_keybuf #(.NUM_DIGITS(6), .DIGIT_W(4), .KEY_MAX(9), .TIMEOUT_TICKS(10)) u_b (
        .clock(clk), .reset(rst), .kb(ib)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic c, logic b, logic s, logic [3:0] k, logic t,
                                logic [15:0] d, int n, logic e, logic o);
        vec_t v;
        v.r = r; v.c = c; v.b = b; v.s = s; v.k = k; v.t = t;
        v.d = d; v.n = n; v.e = e; v.o = o;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic mzero(int k);
        for (int i = 0; i < 8; i++) md[k][i] = 0;
        mc[k] = 0;
        mt[k] = 0;
    endtask

    function automatic logic [63:0] mflat(int k);
        logic [63:0] r = '0;
        for (int i = 0; i < MN[k]; i++) r |= 64'(md[k][i]) << (4 * i);
        return r;
    endfunction

    task automatic mstep(int k);
        me[k] = 0;
        mo[k] = 0;
        if (rst || clr) mzero(k);
        else if (bs) begin
            if (mc[k] > 0) begin
                for (int i = 0; i < MN[k] - 1; i++) md[k][i] = md[k][i+1];
                md[k][MN[k]-1] = 0;
                mc[k]--;
                mt[k] = 0;
            end
        end else if (sh) begin
            mt[k] = 0;
            if (key <= 9) begin
                for (int i = MN[k] - 1; i > 0; i--) md[k][i] = md[k][i-1];
                md[k][0] = int'(key);
                if (mc[k] < MN[k]) mc[k]++;
            end else me[k] = 1;
        end else if (tick && mc[k] > 0 && mc[k] < MN[k]) begin
            mt[k]++;
            if (mt[k] == MT[k]) begin
                mzero(k);
                mo[k] = 1;
            end
        end
    endtask

    task automatic mcmp();
        chk("A.digits", 64'(ia.digits), mflat(0));
        chk("A.count", 64'(ia.count), 64'(mc[0]));
        chk("A.full", 64'(ia.full), 64'(mc[0] == MN[0]));
        chk("A.key_err", 64'(ia.key_err), 64'(me[0]));
        chk("A.timeout", 64'(ia.timeout), 64'(mo[0]));
        chk("B.digits", 64'(ib.digits), mflat(1));
        chk("B.count", 64'(ib.count), 64'(mc[1]));
        chk("B.full", 64'(ib.full), 64'(mc[1] == MN[1]));
        chk("B.key_err", 64'(ib.key_err), 64'(me[1]));
        chk("B.timeout", 64'(ib.timeout), 64'(mo[1]));
    endtask

    task automatic step();
        @(posedge clk);
        mstep(0);
        mstep(1);
        @(negedge clk);
        mcmp();
    endtask

    task automatic drive(logic r, logic c, logic b, logic s, logic [3:0] k, logic t);
        rst = r; clr = c; bs = b; sh = s; key = k; tick = t;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        mzero(0);
        mzero(1);

        tv.push_back(mk(1,0,0,0,4'h0,0,16'h0000,0,0,0));
        tv.push_back(mk(0,0,0,1,4'h1,0,16'h0001,1,0,0));
        tv.push_back(mk(0,0,0,1,4'h2,0,16'h0012,2,0,0));
        tv.push_back(mk(0,0,0,1,4'h3,0,16'h0123,3,0,0));
        tv.push_back(mk(0,0,0,1,4'h4,0,16'h1234,4,0,0));
        tv.push_back(mk(0,0,0,1,4'h5,0,16'h2345,4,0,0));
        tv.push_back(mk(0,1,0,0,4'h0,0,16'h0000,0,0,0));
        tv.push_back(mk(0,0,0,1,4'h1,0,16'h0001,1,0,0));
        tv.push_back(mk(0,0,0,1,4'h2,0,16'h0012,2,0,0));
        tv.push_back(mk(0,0,0,1,4'h3,0,16'h0123,3,0,0));
        tv.push_back(mk(0,0,1,0,4'h0,0,16'h0012,2,0,0));
        tv.push_back(mk(0,0,0,1,4'hA,0,16'h0012,2,1,0));
        tv.push_back(mk(0,0,0,0,4'h0,0,16'h0012,2,0,0));
        tv.push_back(mk(0,0,1,0,4'h0,0,16'h0001,1,0,0));
        tv.push_back(mk(0,0,1,0,4'h0,0,16'h0000,0,0,0));
        tv.push_back(mk(0,0,1,0,4'h0,0,16'h0000,0,0,0));
        tv.push_back(mk(0,0,0,1,4'h7,0,16'h0007,1,0,0));
        tv.push_back(mk(0,0,0,0,4'h0,1,16'h0007,1,0,0));
        tv.push_back(mk(0,0,0,0,4'h0,1,16'h0007,1,0,0));
        tv.push_back(mk(0,0,0,0,4'h0,1,16'h0000,0,0,1));
        tv.push_back(mk(0,0,0,0,4'h0,0,16'h0000,0,0,0));
        tv.push_back(mk(0,0,0,1,4'h7,0,16'h0007,1,0,0));
        tv.push_back(mk(0,0,0,0,4'h0,1,16'h0007,1,0,0));
        tv.push_back(mk(0,0,0,0,4'h0,1,16'h0007,1,0,0));
        tv.push_back(mk(0,0,0,1,4'h7,1,16'h0077,2,0,0));
        tv.push_back(mk(0,0,0,0,4'h0,1,16'h0077,2,0,0));
        tv.push_back(mk(0,0,0,1,4'h9,0,16'h0779,3,0,0));
        tv.push_back(mk(0,1,0,1,4'h9,0,16'h0000,0,0,0));
        tv.push_back(mk(0,0,0,1,4'h9,0,16'h0009,1,0,0));
        tv.push_back(mk(1,0,0,1,4'h5,0,16'h0000,0,0,0));
        tv.push_back(mk(0,0,0,1,4'h7,0,16'h0007,1,0,0));
        tv.push_back(mk(0,0,0,0,4'h0,1,16'h0007,1,0,0));
        tv.push_back(mk(0,0,0,0,4'h0,1,16'h0007,1,0,0));
        tv.push_back(mk(0,0,0,1,4'hA,0,16'h0007,1,1,0));
        tv.push_back(mk(0,0,0,0,4'h0,1,16'h0007,1,0,0));
        tv.push_back(mk(0,0,0,0,4'h0,1,16'h0007,1,0,0));
        tv.push_back(mk(0,0,0,0,4'h0,1,16'h0000,0,0,1));

        foreach (tv[i]) begin
            drive(tv[i].r, tv[i].c, tv[i].b, tv[i].s, tv[i].k, tv[i].t);
            step();
            chk($sformatf("T%0d.digits", i), 64'(ia.digits), 64'(tv[i].d));
            chk($sformatf("T%0d.count", i), 64'(ia.count), 64'(tv[i].n));
            chk($sformatf("T%0d.full", i), 64'(ia.full), 64'(tv[i].n == 4));
            chk($sformatf("T%0d.key_err", i), 64'(ia.key_err), 64'(tv[i].e));
            chk($sformatf("T%0d.timeout", i), 64'(ia.timeout), 64'(tv[i].o));
        end

        drive(0, 1, 0, 0, 0, 0);
        step();
        for (int i = 1; i <= 7; i++) begin
            drive(0, 0, 0, 1, 4'(i), 0);
            step();
        end
        chk("B6.digits", 64'(ib.digits), 64'h234567);
        chk("B6.count", 64'(ib.count), 64'd6);
        chk("B6.full", 64'(ib.full), 64'd1);
        chk("B6.msdigit", 64'(digit_at(64'(ib.digits), 5, 4)), 64'd2);

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aclk_keybuf.md
# aclk_keybuf

Parametrised successor to the alarm-clock key register: a NUM_DIGITS-deep shift buffer of DIGIT_W-bit key codes with entry counting, backspace, clear, invalid-key rejection and inactivity timeout. It sits between the keypad decoder and the alarm/time registers in the alarm clock. Completed entries are presented as a flat digit bus. Digit 0 is least significant (ls_min in the 4-digit build).

## Interface
- NUM_DIGITS, 4: buffer depth in digits; legal range 2..8.
- DIGIT_W, 4: bits per key code.
- KEY_MAX, 9: largest accepted key code; larger codes are rejected.
- TIMEOUT_TICKS, 10: tick pulses of inactivity before a partial entry is auto-cleared; 0 disables the timeout.

- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- key  in  DIGIT_W  key code, sampled when shift=1.
- shift  in  1  push strobe; acts in every cycle it is high.
- backspace  in  1  remove the most recent digit.
- clear  in  1  empty the buffer.
- tick  in  1  one-cycle timebase pulse (one_second).
- digits  out  NUM_DIGITS*DIGIT_W  digit i occupies bits [i*DIGIT_W +: DIGIT_W].
- count  out  clog2(NUM_DIGITS+1)  number of digits entered, saturating.
- full  out  1  count==NUM_DIGITS.
- key_err  out  1  one-cycle pulse: shift with key>KEY_MAX.
- timeout  out  1  one-cycle pulse: auto-clear fired.

## Operation
- Commands are priority-resolved each cycle: reset > clear > backspace > shift. Only the highest-priority command acts.
- Shift with a valid key:
  - digit[i] <= digit[i-1] for i>0; digit[0] <= key.
  - count increments and saturates at NUM_DIGITS.
  - When full, digit[NUM_DIGITS-1] is discarded; this matches legacy overwrite behaviour.
- Shift with key>KEY_MAX: digits and count are unchanged; key_err pulses. The attempt still counts as activity for the timeout.
- Backspace:
  - digit[i] <= digit[i+1]; the MS digit is zero-filled.
  - count decrements.
  - When count==0, backspace is a no-op and is not activity.
- Clear: all digits <= 0, count <= 0, timer <= 0.
- Mode FSM, derived from count and registered:
  - EMPTY (count 0) -> ENTRY on valid shift.
  - ENTRY -> FULL when count reaches NUM_DIGITS.
  - FULL -> ENTRY on backspace.
  - Any state -> EMPTY on clear, timeout or reset.
  - ENTRY -> EMPTY on a backspace that leaves count 0.
- Timeout:
  - An inactivity counter increments on tick while the mode is ENTRY.
  - It is zeroed by any activity (shift or effective backspace).
  - When it reaches TIMEOUT_TICKS, the buffer clears and timeout pulses.
  - FULL and EMPTY never time out.

## Timing
- Reset values: digits=0, count=0, full=0, key_err=0, timeout=0, mode=EMPTY, timer=0.
- Latency: a command at edge N is visible on digits, count and full after edge N, i.e. in cycle N+1. All outputs are registered.
- key_err and timeout are high for exactly one cycle after the triggering edge.
- A held shift of K cycles inserts K copies of key.
- Simultaneous events:
  - tick reaching the limit in the same cycle as a shift: the shift wins, the timer zeroes, and there is no timeout.
  - Same cycle as backspace or clear: the higher-priority command applies and the timer zeroes.
- Reset asserted mid-entry: at the next edge all state returns to reset values, overriding every other input.
- Width rule: count width is clog2(NUM_DIGITS+1). The timer width is clog2(TIMEOUT_TICKS+1), with a minimum of 1.

## Structure
- Shared package aclk_pkg holds:
  - DIGIT_W default and KEY_MAX default.
  - The mode enum {MODE_EMPTY, MODE_ENTRY, MODE_FULL}.
  - A helper function that extracts digit i from the flat bus.
- One sub-module, aclk_idle_timer: a tick counter with clear and enable inputs and a done pulse. It is parametrised by TIMEOUT_TICKS and is reused by the future alarm-snooze logic.
- The top level contains the digit array, command priority decode, count and FSM.

## Test plan
- Reset, then shift 1,2,3,4 (one cycle each) -> digits = 0x1234, count=4, full=1. Then shift 5 -> 0x2345, count stays 4.
- Load 1,2,3, then backspace -> digits=0x0012, count=2. Backspace twice more -> 0x0000, count=0. A further backspace -> no change.
- Shift key=4'hA with count=2 -> key_err pulses for 1 cycle; digits and count are unchanged.
- TIMEOUT_TICKS=3: shift 7, then three ticks with no keys -> timeout pulses, digits=0, count=0. Repeat with a shift coinciding with the third tick -> no timeout, digits=0x0077.
- Assert clear and shift together with key=9 at count=2 -> buffer empties and 9 is not inserted. Assert reset and shift together -> all outputs at reset values.
- NUM_DIGITS=6, DIGIT_W=4: shift 1..7 -> digits=0x234567, count=6, full=1.
